// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_NUM_SETS = 8;
  localparam int DEF_WPB      = 4;

  localparam int OFFSET_W = $clog2(DEF_WPB);
  localparam int INDEX_W  = $clog2(DEF_NUM_SETS);
  localparam int TAG_W    = DEF_ADDR_W - 2 - OFFSET_W - INDEX_W;
  localparam int BLOCK_W  = 32 * DEF_WPB;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    UPDATE = 2'b10
  } state_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one write port, one combinational read port.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int IW       = INDEX_W,
  parameter int TW       = TAG_W,
  parameter int BW       = BLOCK_W
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_we,
  input  logic [IW-1:0] i_windex,
  input  logic [TW-1:0] i_wtag,
  input  logic [BW-1:0] i_wblock,
  input  logic [IW-1:0] i_rindex,
  output logic          o_valid,
  output logic [TW-1:0] o_tag,
  output logic [BW-1:0] o_block
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TW-1:0]       r_tag  [NUM_SETS];
  logic [BW-1:0]       r_data [NUM_SETS];

  // Only the valid bits are cleared; tag and data contents are don't-care until valid.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_windex] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_tag[i_windex]  <= i_wtag;
      r_data[i_windex] <= i_wblock;
    end
  end

  assign o_valid = r_valid[i_rindex];
  assign o_tag   = r_tag[i_rindex];
  assign o_block = r_data[i_rindex];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache: tag compare, word select and refill FSM.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter  int ADDR_W          = DEF_ADDR_W,
  parameter  int NUM_SETS        = DEF_NUM_SETS,
  parameter  int WORDS_PER_BLOCK = DEF_WPB,
  localparam int C_OFF_W         = $clog2(WORDS_PER_BLOCK),
  localparam int C_IDX_W         = $clog2(NUM_SETS),
  localparam int C_TAG_W         = ADDR_W - 2 - C_OFF_W - C_IDX_W,
  localparam int C_BLK_W         = 32 * WORDS_PER_BLOCK
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [ADDR_W-1:0]           ADDRESS,
  output logic [31:0]                 INSTRUCTION,
  output logic                        BUSYWAIT,
  output logic                        MEM_READ,
  output logic [C_TAG_W+C_IDX_W-1:0]  MEM_ADDRESS,
  input  logic [C_BLK_W-1:0]          MEM_READDATA,
  input  logic                        MEM_BUSYWAIT
);

  state_t                                  r_state;
  logic                                    r_mem_read;
  logic [C_BLK_W-1:0]                      r_fill;

  logic [C_OFF_W-1:0]                      w_offset;
  logic [C_IDX_W-1:0]                      w_index;
  logic [C_TAG_W-1:0]                      w_tag;
  logic                                    w_valid;
  logic [C_TAG_W-1:0]                      w_tag_rd;
  logic [C_BLK_W-1:0]                      w_block;
  logic [WORDS_PER_BLOCK-1:0][31:0]        w_words;
  logic                                    w_hit;
  logic                                    w_unused_lsb;

  assign w_offset     = ADDRESS[C_OFF_W+1:2];
  assign w_index      = ADDRESS[C_OFF_W+C_IDX_W+1:C_OFF_W+2];
  assign w_tag        = ADDRESS[ADDR_W-1:ADDR_W-C_TAG_W];
  assign w_unused_lsb = ^ADDRESS[1:0];

  icache_line_store #(
    .NUM_SETS (NUM_SETS),
    .IW       (C_IDX_W),
    .TW       (C_TAG_W),
    .BW       (C_BLK_W)
  ) u_store (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_we     (r_state == UPDATE),
    .i_windex (w_index),
    .i_wtag   (w_tag),
    .i_wblock (r_fill),
    .i_rindex (w_index),
    .o_valid  (w_valid),
    .o_tag    (w_tag_rd),
    .o_block  (w_block)
  );

  assign w_hit       = w_valid & (w_tag_rd == w_tag);
  assign w_words     = w_block;
  assign INSTRUCTION = w_words[w_offset];
  assign MEM_ADDRESS = {w_tag, w_index};
  assign MEM_READ    = r_mem_read;
  // Held low during reset so the PC's reset value never looks like a pending fetch.
  assign BUSYWAIT    = RESET ? 1'b0 : ((r_state == IDLE) ? ~w_hit : 1'b1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_mem_read <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_hit) begin
            r_state    <= FETCH;
            r_mem_read <= 1'b1;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            r_state    <= UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        UPDATE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Capture the block in the cycle memory presents it; written to the line in UPDATE.
  always_ff @(posedge CLK) begin
    if ((r_state == FETCH) && !MEM_BUSYWAIT) begin
      r_fill <= MEM_READDATA;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios plus random fetches against a cache/memory model.
module tb_icache_ctrl;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [9:0]   ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b0;

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int ncmp = 0;
  int nerr = 0;

  // Backing instruction memory: 64 blocks of four words
  logic [127:0] bmem [64];
  int           mem_lat = 0;
  int           mcnt    = 0;

  // Cache model: what each line should hold
  bit           mvalid [8];
  int           mtag   [8];
  logic [127:0] mdata  [8];

  // Memory responder: busy for mem_lat FETCH cycles, then presents the block.
  always @(posedge CLK) begin
    #1;
    if (MEM_READ) begin
      if (mcnt < mem_lat) begin
        MEM_BUSYWAIT = 1'b1;
        mcnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
      mcnt = 0;
    end
    MEM_READDATA = bmem[MEM_ADDRESS];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one fetch address and follow it until the cache delivers the word.
  task automatic do_fetch(input logic [9:0] a, output int stalls);
    int idx, tg, off, blk, lat;
    logic [127:0] line;
    idx = (int'(a) >> 4) % 8;
    tg  = int'(a) >> 7;
    off = (int'(a) >> 2) % 4;
    blk = int'(a) >> 4;
    lat = mem_lat;
    stalls = 0;
    ADDRESS = a;
    #1;
    if (!(mvalid[idx] && mtag[idx] == tg)) begin
      // Miss penalty: one IDLE edge, lat+1 FETCH edges, one UPDATE edge.
      for (int c = 0; c < lat + 3; c++) begin
        chk("miss_busywait", 32'(BUSYWAIT), 32'd1);
        if (c >= 1 && c <= lat + 1) begin
          chk("miss_mem_read", 32'(MEM_READ), 32'd1);
          chk("miss_mem_addr", 32'(MEM_ADDRESS), 32'(blk));
        end else begin
          chk("miss_mem_read_idle", 32'(MEM_READ), 32'd0);
        end
        stalls++;
        @(posedge CLK);
        @(negedge CLK);
        #1;
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdata[idx]  = bmem[blk];
    end
    line = mdata[idx];
    chk("hit_busywait", 32'(BUSYWAIT), 32'd0);
    chk("hit_mem_read", 32'(MEM_READ), 32'd0);
    chk("hit_instr", INSTRUCTION, line[off*32 +: 32]);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int st;
    for (int b = 0; b < 64; b++) bmem[b] = {$urandom, $urandom, $urandom, $urandom};
    bmem[0] = {32'h33, 32'h22, 32'h11, 32'h00};
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = 0;
      mdata[i]  = '0;
    end

    // Held in reset with the PC's reset value on the bus
    RESET   = 1'b1;
    ADDRESS = 10'h3FC;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
      chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    end
    @(negedge CLK);
    RESET = 1'b0;

    // Cold miss on line 0, four-cycle memory
    mem_lat = 4;
    do_fetch(10'h000, st);
    chk("cold_stalls", 32'(st), 32'd7);
    chk("cold_word0", INSTRUCTION, 32'h00);

    // Sequential hits within the filled block
    do_fetch(10'h004, st);
    chk("sweep_stall_4", 32'(st), 32'd0);
    do_fetch(10'h008, st);
    chk("sweep_stall_8", 32'(st), 32'd0);
    do_fetch(10'h00C, st);
    chk("sweep_stall_C", 32'(st), 32'd0);

    // Conflict miss on index 0, then back to tag 0
    mem_lat = 2;
    do_fetch(10'h080, st);
    chk("conflict_stalls", 32'(st), 32'd5);
    do_fetch(10'h000, st);
    chk("conflict_back_stalls", 32'(st), 32'd5);
    do_fetch(10'h004, st);

    // Reset asserted while memory is still busy
    mem_lat = 20;
    ADDRESS = 10'h040;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("abort_pre_read", 32'(MEM_READ), 32'd1);
    chk("abort_pre_busy", 32'(BUSYWAIT), 32'd1);
    chk("abort_pre_addr", 32'(MEM_ADDRESS), 32'h04);
    RESET = 1'b1;
    #1;
    chk("abort_read", 32'(MEM_READ), 32'd0);
    chk("abort_busy", 32'(BUSYWAIT), 32'd0);
    ADDRESS = 10'h3FC;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("abort_hold_read", 32'(MEM_READ), 32'd0);
    chk("abort_hold_busy", 32'(BUSYWAIT), 32'd0);
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    RESET = 1'b0;
    mem_lat = 1;
    do_fetch(10'h004, st);
    chk("after_abort_miss", 32'(st), 32'd4);

    // Zero-latency memory and the index 7 -> index 0 wrap
    mem_lat = 0;
    do_fetch(10'h3F0, st);
    chk("zero_lat_stalls", 32'(st), 32'd3);
    do_fetch(10'h3FC, st);
    chk("idx7_hit", 32'(st), 32'd0);
    do_fetch(10'h000, st);
    do_fetch(10'h3F4, st);
    chk("idx7_still_hit", 32'(st), 32'd0);

    // Random fetch stream over two tags per set
    for (int n = 0; n < 40; n++) begin
      logic [9:0] a;
      a = {1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      mem_lat = $urandom_range(0, 3);
      do_fetch(a, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
